// File: rtl/mpu_mapman_ring.sv
// mpu_mapman_ring: ring-order instruction-memory allocator with associative thread-ID lookup,
// release-on-lookup and in-order reclamation of released regions.
module mpu_mapman_ring #(
    parameter int NUM_ENTRY  = 8,
    parameter int MEM_SIZE   = 1024,
    parameter int WIDTH_ID   = 8,
    parameter int WIDTH_ADDR = $clog2(MEM_SIZE)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         I_Req_St,
    input  logic [WIDTH_ID-1:0]          I_ThreadID_St,
    input  logic [WIDTH_ADDR:0]          I_Length_St,
    output logic                         O_Ack_St,
    output logic                         O_Nack_St,
    output logic [WIDTH_ADDR-1:0]        O_Addr_St,
    input  logic                         I_Req_Lookup,
    input  logic [WIDTH_ID-1:0]          I_ThreadID_Ld,
    input  logic                         I_Release,
    output logic                         O_Ack_Lookup,
    output logic                         O_Hit,
    output logic [WIDTH_ADDR-1:0]        O_Address,
    output logic [WIDTH_ADDR:0]          O_Length,
    output logic [WIDTH_ADDR:0]          O_Used_Size,
    output logic [$clog2(NUM_ENTRY):0]   O_Num,
    output logic                         O_Full,
    output logic                         O_Empty
);
    localparam int WE = $clog2(NUM_ENTRY);
    localparam int WL = WIDTH_ADDR + 1;
    localparam logic [WL-1:0] MEM_W = WL'(MEM_SIZE);
    localparam logic [WE:0]   NUM_W = (WE+1)'(NUM_ENTRY);

    logic [NUM_ENTRY-1:0]  valid, live;
    logic [WIDTH_ID-1:0]   tid  [NUM_ENTRY];
    logic [WIDTH_ADDR-1:0] base [NUM_ENTRY];
    logic [WL-1:0]         len  [NUM_ENTRY];
    logic [WE-1:0]         wptr, rptr, ld_idx;
    logic [WIDTH_ADDR-1:0] tail;
    logic [WL-1:0]         used;
    logic [WE:0]           num;
    logic                  dup, ld_hit, accept, reclaim, lk_hit;

    // Downward scan leaves the lowest matching index in ld_idx.
    always_comb begin
        dup    = 1'b0;
        ld_hit = 1'b0;
        ld_idx = '0;
        for (int i = NUM_ENTRY - 1; i >= 0; i--) begin
            if (live[i] && tid[i] == I_ThreadID_St) dup = 1'b1;
            if (live[i] && tid[i] == I_ThreadID_Ld) begin
                ld_hit = 1'b1;
                ld_idx = WE'(i);
            end
        end
    end

    // Capacity is judged against pre-reclaim occupancy.
    assign accept  = I_Req_St && num < NUM_W && I_Length_St != '0 &&
                     I_Length_St <= MEM_W - used && !dup;
    assign reclaim = valid[rptr] && !live[rptr];
    assign lk_hit  = I_Req_Lookup && ld_hit;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid        <= '0;
            live         <= '0;
            for (int i = 0; i < NUM_ENTRY; i++) begin
                tid[i]  <= '0;
                base[i] <= '0;
                len[i]  <= '0;
            end
            wptr         <= '0;
            rptr         <= '0;
            tail         <= '0;
            used         <= '0;
            num          <= '0;
            O_Ack_St     <= 1'b0;
            O_Nack_St    <= 1'b0;
            O_Addr_St    <= '0;
            O_Ack_Lookup <= 1'b0;
            O_Hit        <= 1'b0;
            O_Address    <= '0;
            O_Length     <= '0;
        end else begin
            O_Ack_St     <= accept;
            O_Nack_St    <= I_Req_St && !accept;
            O_Ack_Lookup <= I_Req_Lookup;
            O_Hit        <= lk_hit;
            O_Address    <= lk_hit ? base[ld_idx] : '0;
            O_Length     <= lk_hit ? len[ld_idx] : '0;
            if (accept) begin
                valid[wptr] <= 1'b1;
                live[wptr]  <= 1'b1;
                tid[wptr]   <= I_ThreadID_St;
                base[wptr]  <= tail;
                len[wptr]   <= I_Length_St;
                O_Addr_St   <= tail;
                tail        <= tail + I_Length_St[WIDTH_ADDR-1:0];
                wptr        <= wptr + 1'b1;
            end
            if (reclaim) begin
                valid[rptr] <= 1'b0;
                rptr        <= rptr + 1'b1;
            end
            if (lk_hit && I_Release) live[ld_idx] <= 1'b0;
            used <= used + (accept ? I_Length_St : WL'(0)) - (reclaim ? len[rptr] : WL'(0));
            num  <= num + (WE+1)'(accept) - (WE+1)'(reclaim);
        end
    end

    assign O_Used_Size = used;
    assign O_Num       = num;
    assign O_Full      = num == NUM_W || used == MEM_W;
    assign O_Empty     = num == '0;
endmodule

// File: tb/tb_mpu_mapman_ring.sv
// tb_mpu_mapman_ring: directed checks of allocation, lookup/release, reclamation,
// capacity limits, address wrap and asynchronous reset.
module tb_mpu_mapman_ring;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        I_Req_St = 1'b0, I_Req_Lookup = 1'b0, I_Release = 1'b0;
    logic [7:0]  I_ThreadID_St = '0, I_ThreadID_Ld = '0;
    logic [10:0] I_Length_St = '0;
    logic        O_Ack_St, O_Nack_St, O_Ack_Lookup, O_Hit, O_Full, O_Empty;
    logic [9:0]  O_Addr_St, O_Address;
    logic [10:0] O_Length, O_Used_Size;
    logic [3:0]  O_Num;
    int n_cmp = 0, n_err = 0;

    mpu_mapman_ring dut (
        .clock(clock), .reset(reset),
        .I_Req_St(I_Req_St), .I_ThreadID_St(I_ThreadID_St), .I_Length_St(I_Length_St),
        .O_Ack_St(O_Ack_St), .O_Nack_St(O_Nack_St), .O_Addr_St(O_Addr_St),
        .I_Req_Lookup(I_Req_Lookup), .I_ThreadID_Ld(I_ThreadID_Ld), .I_Release(I_Release),
        .O_Ack_Lookup(O_Ack_Lookup), .O_Hit(O_Hit), .O_Address(O_Address), .O_Length(O_Length),
        .O_Used_Size(O_Used_Size), .O_Num(O_Num), .O_Full(O_Full), .O_Empty(O_Empty)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: drive at negedge, return just after the posedge.
    task automatic cyc(input logic st, input int sid, input int slen,
                       input logic lk, input int lid, input logic rel);
        @(negedge clock);
        I_Req_St = st; I_ThreadID_St = 8'(sid); I_Length_St = 11'(slen);
        I_Req_Lookup = lk; I_ThreadID_Ld = 8'(lid); I_Release = rel;
        @(posedge clock);
        #1;
        I_Req_St = 1'b0; I_Req_Lookup = 1'b0; I_Release = 1'b0;
    endtask

    task automatic st_ack(input string tag, input int sid, input int slen, input int addr);
        cyc(1, sid, slen, 0, 0, 0);
        chk({tag, "_ack"}, O_Ack_St, 1);
        chk({tag, "_addr"}, O_Addr_St, addr);
    endtask

    task automatic st_nack(input string tag, input int sid, input int slen);
        cyc(1, sid, slen, 0, 0, 0);
        chk({tag, "_nack"}, O_Nack_St, 1);
        chk({tag, "_noack"}, O_Ack_St, 0);
    endtask

    task automatic lk_hit(input string tag, input int lid, input logic rel, input int addr, input int len);
        cyc(0, 0, 0, 1, lid, rel);
        chk({tag, "_hit"}, O_Hit, 1);
        chk({tag, "_addr"}, O_Address, addr);
        chk({tag, "_len"}, O_Length, len);
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        chk("rst_ack_st", O_Ack_St, 0);
        chk("rst_nack_st", O_Nack_St, 0);
        chk("rst_addr_st", O_Addr_St, 0);
        chk("rst_ack_lk", O_Ack_Lookup, 0);
        chk("rst_used", O_Used_Size, 0);
        chk("rst_num", O_Num, 0);
        chk("rst_full", O_Full, 0);
        chk("rst_empty", O_Empty, 1);
        @(negedge clock);
        reset = 1'b1;

        st_ack("st5", 5, 100, 0);
        st_ack("st6", 6, 50, 100);
        chk("used150", O_Used_Size, 150);
        chk("num2", O_Num, 2);
        lk_hit("lk6", 6, 0, 100, 50);
        chk("lk6_ack", O_Ack_Lookup, 1);
        chk("lk6_used", O_Used_Size, 150);

        lk_hit("rel6", 6, 1, 100, 50);
        cyc(0, 0, 0, 0, 0, 0);
        chk("ooo_used", O_Used_Size, 150);
        cyc(0, 0, 0, 1, 6, 0);
        chk("lk6_miss_ack", O_Ack_Lookup, 1);
        chk("lk6_miss_hit", O_Hit, 0);
        chk("lk6_miss_addr", O_Address, 0);
        chk("lk6_miss_len", O_Length, 0);
        lk_hit("rel5", 5, 1, 0, 100);
        chk("rel5_used_t", O_Used_Size, 150);
        cyc(0, 0, 0, 0, 0, 0);
        chk("rel5_used_t1", O_Used_Size, 50);
        chk("rel5_num_t1", O_Num, 1);
        cyc(0, 0, 0, 0, 0, 0);
        chk("rel5_used_t2", O_Used_Size, 0);
        chk("rel5_empty", O_Empty, 1);

        st_ack("st7_full", 7, 1024, 150);
        chk("full_mem", O_Full, 1);
        chk("used1024", O_Used_Size, 1024);
        st_nack("st8_nospace", 8, 1);
        st_nack("st9_len0", 9, 0);
        lk_hit("rel7", 7, 1, 150, 1024);
        cyc(0, 0, 0, 0, 0, 0);
        chk("rel7_used", O_Used_Size, 0);

        st_ack("st10", 10, 10, 150);
        st_nack("st10_dup", 10, 10);
        st_nack("st19_len0", 19, 0);
        for (int i = 0; i < 7; i++) st_ack("fill", 11 + i, 1, 160 + i);
        chk("fill_num", O_Num, 8);
        chk("fill_full", O_Full, 1);
        chk("fill_used", O_Used_Size, 17);
        st_nack("st20_noentry", 20, 1);
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1, 10 + i, 1);
        repeat (2) cyc(0, 0, 0, 0, 0, 0);
        chk("drain_used", O_Used_Size, 0);
        chk("drain_num", O_Num, 0);

        st_ack("st30", 30, 4, 167);
        @(negedge clock);
        I_Req_Lookup = 1'b1; I_ThreadID_Ld = 8'd30;
        #2 reset = 1'b0;
        #1;
        chk("arst_ack_st", O_Ack_St, 0);
        chk("arst_addr_st", O_Addr_St, 0);
        chk("arst_used", O_Used_Size, 0);
        chk("arst_num", O_Num, 0);
        chk("arst_empty", O_Empty, 1);
        @(posedge clock);
        #1;
        chk("arst_ack_lk", O_Ack_Lookup, 0);
        chk("arst_hit", O_Hit, 0);
        @(negedge clock);
        I_Req_Lookup = 1'b0;
        reset = 1'b1;

        st_ack("st40", 40, 1000, 0);
        st_ack("st41", 41, 24, 1000);
        chk("wrap_full", O_Full, 1);
        lk_hit("rel40", 40, 1, 0, 1000);
        lk_hit("rel41", 41, 1, 1000, 24);
        chk("wrap_used_mid", O_Used_Size, 24);
        cyc(0, 0, 0, 0, 0, 0);
        chk("wrap_used0", O_Used_Size, 0);
        st_ack("st42_wrap", 42, 100, 0);
        lk_hit("rel42", 42, 1, 0, 100);
        cyc(0, 0, 0, 0, 0, 0);
        st_ack("st43", 43, 900, 100);
        lk_hit("rel43", 43, 1, 100, 900);
        cyc(0, 0, 0, 0, 0, 0);
        st_ack("st44_straddle", 44, 30, 1000);
        st_ack("st45", 45, 10, 6);
        lk_hit("lk44", 44, 0, 1000, 30);
        chk("straddle_used", O_Used_Size, 40);

        cyc(1, 45, 5, 1, 45, 1);
        chk("relstore_nack", O_Nack_St, 1);
        chk("relstore_hit", O_Hit, 1);
        chk("relstore_len", O_Length, 10);
        cyc(1, 46, 5, 1, 46, 0);
        chk("samecyc_ack", O_Ack_St, 1);
        chk("samecyc_addr", O_Addr_St, 16);
        chk("samecyc_lkack", O_Ack_Lookup, 1);
        chk("samecyc_miss", O_Hit, 0);
        st_ack("st45_again", 45, 5, 21);
        chk("end_used", O_Used_Size, 50);
        chk("end_num", O_Num, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mpu_mapman_ring.md
# mpu_mapman_ring

Parametrised thread-program map manager for the MPU instruction memory. Allocates instruction-memory regions to incoming thread programs in ring order, and resolves dispatch-unit lookups by thread ID through a fully associative search. Supports optional release-on-lookup, out-of-order release with in-order space reclamation, and explicit rejection (NACK) of stores that cannot be placed. Sits between the instruction-memory loader (store side) and the dispatch unit (lookup side).

## Interface
Parameters:
- NUM_ENTRY, 8: map-table entries; power of two, ≥2.
- MEM_SIZE, 1024: instruction-memory words; power of two.
- WIDTH_ID, 8: thread-ID width.
- WIDTH_ADDR, $clog2(MEM_SIZE): address width (derived).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- I_Req_St  in  1  store request, single-cycle pulse.
- I_ThreadID_St  in  WIDTH_ID  thread ID of the program being stored.
- I_Length_St  in  WIDTH_ADDR+1  program length in words.
- O_Ack_St  out  1  store accepted, one-cycle pulse.
- O_Nack_St  out  1  store rejected, one-cycle pulse.
- O_Addr_St  out  WIDTH_ADDR  base address granted; valid with O_Ack_St.
- I_Req_Lookup  in  1  lookup request, single-cycle pulse.
- I_ThreadID_Ld  in  WIDTH_ID  thread ID to look up.
- I_Release  in  1  with I_Req_Lookup: release the entry on a hit.
- O_Ack_Lookup  out  1  lookup response, one-cycle pulse.
- O_Hit  out  1  lookup matched a live entry; valid with O_Ack_Lookup.
- O_Address  out  WIDTH_ADDR  base address of the matched program (0 on miss).
- O_Length  out  WIDTH_ADDR+1  length of the matched program (0 on miss).
- O_Used_Size  out  WIDTH_ADDR+1  occupied words, including released-but-unreclaimed words.
- O_Num  out  $clog2(NUM_ENTRY)+1  number of occupied entries.
- O_Full  out  1  O_Num==NUM_ENTRY or O_Used_Size==MEM_SIZE.
- O_Empty  out  1  O_Num==0.

## Operation
- Each entry holds {Valid, Live, ThreadID, Address, Length}. Entries are allocated at ring pointer WPtr and reclaimed at RPtr, both modulo NUM_ENTRY. R_Tail is the next free memory address, modulo MEM_SIZE.
- Store decision, evaluated on pre-edge state when I_Req_St=1. Accept only if all of the following hold:
  - O_Num<NUM_ENTRY;
  - I_Length_St≠0;
  - I_Length_St ≤ MEM_SIZE−R_Used;
  - no Live entry has ThreadID==I_ThreadID_St.
- On accept:
  - entry[WPtr] ← {1,1,ID,R_Tail,Len};
  - O_Addr_St ← R_Tail;
  - R_Tail += Len (wraps modulo MEM_SIZE; a program may straddle the memory end);
  - WPtr++; R_Used += Len.
- On reject: no state change except the O_Nack_St pulse.
- Lookup: associative compare of I_ThreadID_Ld against all entries with Live=1. At most one match exists; the match is priority-encoded to the lowest index as a defensive measure.
  - Hit: the response carries the entry's Address and Length.
  - Hit with I_Release=1: the entry's Live bit clears. Valid stays 1.
  - Miss: O_Address=0 and O_Length=0.
- Reclaim engine: every cycle in which entry[RPtr] has Valid=1 and Live=0:
  - clear its Valid bit;
  - RPtr++;
  - R_Used −= Length.
  - Rate is one entry per cycle; the engine walks contiguous released entries on consecutive cycles.
  - Entries released out of order keep their space until every older entry has been released.
- Released-but-unreclaimed entries never match a lookup. Their thread ID may be stored again immediately.

## Timing
- Reset: every output is 0, all entries invalid, and WPtr, RPtr, R_Tail, R_Used are 0. O_Empty is the exception and reads 1.
- Reset asserted mid-operation clears all state immediately. Pending responses are dropped.
- Store: request sampled at edge t; O_Ack_St or O_Nack_St (exactly one) is high during cycle t+1. Back-to-back requests are accepted every cycle.
- Lookup: sampled at edge t; O_Ack_Lookup, O_Hit, O_Address and O_Length are registered and valid during cycle t+1.
- Release: Live clears at edge t. The earliest reclaim of that entry happens at edge t+1.
- Simultaneous store and reclaim in one cycle: R_Used += Len_st − Len_rc. The capacity check uses pre-reclaim R_Used (conservative).
- Simultaneous store and lookup of the same ID: the lookup misses, because the table updates at the edge.
- Simultaneous release of ID X and store of ID X: the store is rejected as a duplicate, because the check uses pre-edge Live.
- O_Num, O_Full, O_Empty and O_Used_Size are combinational from registered state.

## Test plan
- Reset, then store ID 5 with length 100, then ID 6 with length 50. Expect:
  - ACKs with O_Addr_St=0 and O_Addr_St=100;
  - O_Used_Size=150, O_Num=2.
- Lookup ID 6 with I_Release=0. Expect O_Hit=1, O_Address=100, O_Length=50, then O_Used_Size=150 unchanged.
- Release in the wrong order: release ID 6 first, and O_Used_Size stays 150. Then release ID 5; O_Used_Size drops to 50 at the next edge and to 0 at the edge after.
- Capacity:
  - store length 1024 → ACK;
  - next store of length 1 → NACK;
  - store with length 0 → NACK;
  - duplicate live ID → NACK;
  - with all NUM_ENTRY entries filled, O_Full=1 and the next store → NACK.
- Wrap-around: stores of 1000 then 24, release both, then store 100. Expect O_Addr_St=0, with R_Tail having wrapped through 1024→0. Repeat with 1000 then 30 so the program straddles the memory end at address 1000.
- Reset asserted mid-lookup: no O_Ack_Lookup pulse, and every output returns to its reset value asynchronously.
